// File: rtl/wb_pipe_reg.sv
// wb_pipe_reg: MEM->WB pipeline register with valid/ready flow control,
// synchronous flush and an optional one-entry skid buffer.
//
// Build option:
//   WB_PIPE_SKID_EN defined   - skid entry and SKID state are built; in_ready
//                               is a flop, so out_ready never reaches in_ready
//                               combinationally.
//   WB_PIPE_SKID_EN undefined - single register (EMPTY/FULL only);
//                               in_ready = out_ready || !out_valid.
//
// Whenever the stage becomes empty the output payload is forced to zero, so a
// bubble always presents a NOP write (out_wreg=0) to the register file.

module wb_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_wd,
    input  logic              in_wreg,
    input  logic [DATA_W-1:0] in_wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_wd,
    output logic              out_wreg,
    output logic [DATA_W-1:0] out_wdata
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
`ifdef WB_PIPE_SKID_EN
    localparam logic [1:0] ST_SKID  = 2'd2;
`endif

    logic [1:0]        state_q, state_d;

    // Main entry: this is what the WB stage sees.
    logic [ADDR_W-1:0] main_wd_q,    main_wd_d;
    logic              main_wreg_q,  main_wreg_d;
    logic [DATA_W-1:0] main_wdata_q, main_wdata_d;

    logic              accept;
    logic              consume;

    assign out_valid = (state_q != ST_EMPTY);
    assign out_wd    = main_wd_q;
    assign out_wreg  = main_wreg_q;
    assign out_wdata = main_wdata_q;

    assign accept  = in_valid && in_ready;
    assign consume = out_valid && out_ready;

`ifdef WB_PIPE_SKID_EN

    // Skid entry: holds the one extra word accepted while WB was stalled.
    logic [ADDR_W-1:0] skid_wd_q,    skid_wd_d;
    logic              skid_wreg_q,  skid_wreg_d;
    logic [DATA_W-1:0] skid_wdata_q, skid_wdata_d;
    logic              in_ready_q;

    // in_ready comes straight from a flop: no out_ready -> in_ready path.
    assign in_ready = in_ready_q;

    // Next-state and next-payload selection for the three-state skid build.
    always_comb begin
        // NOTE: every always_comb output gets a default first, otherwise a
        // path that skips an assignment infers a latch.
        state_d      = state_q;
        main_wd_d    = main_wd_q;
        main_wreg_d  = main_wreg_q;
        main_wdata_d = main_wdata_q;
        skid_wd_d    = skid_wd_q;
        skid_wreg_d  = skid_wreg_q;
        skid_wdata_d = skid_wdata_q;

        if (flush) begin
            // Kill both held entries; a same-cycle input handshake is dropped.
            state_d      = ST_EMPTY;
            main_wd_d    = '0;
            main_wreg_d  = 1'b0;
            main_wdata_d = '0;
            skid_wd_d    = '0;
            skid_wreg_d  = 1'b0;
            skid_wdata_d = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d      = ST_FULL;
                        main_wd_d    = in_wd;
                        main_wreg_d  = in_wreg;
                        main_wdata_d = in_wdata;
                    end
                end
                ST_FULL: begin
                    if (accept && consume) begin
                        main_wd_d    = in_wd;
                        main_wreg_d  = in_wreg;
                        main_wdata_d = in_wdata;
                    end else if (accept) begin
                        // WB stalled while a new word arrived: park it.
                        state_d      = ST_SKID;
                        skid_wd_d    = in_wd;
                        skid_wreg_d  = in_wreg;
                        skid_wdata_d = in_wdata;
                    end else if (consume) begin
                        state_d      = ST_EMPTY;
                        main_wd_d    = '0;
                        main_wreg_d  = 1'b0;
                        main_wdata_d = '0;
                    end
                end
                ST_SKID: begin
                    // in_ready is low here, so only a consume can move us.
                    if (consume) begin
                        state_d      = ST_FULL;
                        main_wd_d    = skid_wd_q;
                        main_wreg_d  = skid_wreg_q;
                        main_wdata_d = skid_wdata_q;
                        skid_wd_d    = '0;
                        skid_wreg_d  = 1'b0;
                        skid_wdata_d = '0;
                    end
                end
                default: begin
                    state_d      = ST_EMPTY;
                    main_wd_d    = '0;
                    main_wreg_d  = 1'b0;
                    main_wdata_d = '0;
                    skid_wd_d    = '0;
                    skid_wreg_d  = 1'b0;
                    skid_wdata_d = '0;
                end
            endcase
        end
    end

    // State, payload and registered in_ready update; async reset to an empty NOP.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst) begin
            state_q      <= ST_EMPTY;
            main_wd_q    <= '0;
            main_wreg_q  <= 1'b0;
            main_wdata_q <= '0;
            skid_wd_q    <= '0;
            skid_wreg_q  <= 1'b0;
            skid_wdata_q <= '0;
            in_ready_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            main_wd_q    <= main_wd_d;
            main_wreg_q  <= main_wreg_d;
            main_wdata_q <= main_wdata_d;
            skid_wd_q    <= skid_wd_d;
            skid_wreg_q  <= skid_wreg_d;
            skid_wdata_q <= skid_wdata_d;
            in_ready_q   <= (state_d != ST_SKID);
        end
    end

`else

    // Without a skid entry the stage can only take a word when the current
    // one leaves (or there is none).
    assign in_ready = out_ready || !out_valid;

    // Next-state and next-payload selection for the two-state build.
    always_comb begin
        state_d      = state_q;
        main_wd_d    = main_wd_q;
        main_wreg_d  = main_wreg_q;
        main_wdata_d = main_wdata_q;

        if (flush) begin
            state_d      = ST_EMPTY;
            main_wd_d    = '0;
            main_wreg_d  = 1'b0;
            main_wdata_d = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d      = ST_FULL;
                        main_wd_d    = in_wd;
                        main_wreg_d  = in_wreg;
                        main_wdata_d = in_wdata;
                    end
                end
                ST_FULL: begin
                    // An accept here always coincides with a consume.
                    if (accept) begin
                        main_wd_d    = in_wd;
                        main_wreg_d  = in_wreg;
                        main_wdata_d = in_wdata;
                    end else if (consume) begin
                        state_d      = ST_EMPTY;
                        main_wd_d    = '0;
                        main_wreg_d  = 1'b0;
                        main_wdata_d = '0;
                    end
                end
                default: begin
                    state_d      = ST_EMPTY;
                    main_wd_d    = '0;
                    main_wreg_d  = 1'b0;
                    main_wdata_d = '0;
                end
            endcase
        end
    end

    // State and payload update; async reset to an empty NOP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_EMPTY;
            main_wd_q    <= '0;
            main_wreg_q  <= 1'b0;
            main_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            main_wd_q    <= main_wd_d;
            main_wreg_q  <= main_wreg_d;
            main_wdata_q <= main_wdata_d;
        end
    end

`endif

endmodule

// File: doc/wb_pipe_reg.md
# wb_pipe_reg

Parametrised MEM→WB pipeline register with valid/ready flow control, synchronous flush and an optional one-entry skid buffer. It sits between the MEM stage and the register-file write port. It replaces the free-running stage register with one that can stall without losing data, and can kill an in-flight write on an exception or branch flush. Payload is the write-back triple: destination register, write enable and write data.

## Interface
Parameters:
- DATA_W, default 32, width of write data.
- ADDR_W, default 5, width of destination register address.

Ports:
- clk  input  1  stage clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset; asserted when 0.
- flush  input  1  synchronous kill of all held entries.
- in_valid  input  1  MEM stage presents a valid entry.
- in_ready  output  1  stage accepts an entry this cycle.
- in_wd  input  ADDR_W  destination register address.
- in_wreg  input  1  register write enable.
- in_wdata  input  DATA_W  write data.
- out_valid  output  1  WB entry valid.
- out_ready  input  1  WB consumer accepts the entry this cycle.
- out_wd  output  ADDR_W  registered destination address.
- out_wreg  output  1  registered write enable, never 1 while out_valid=0.
- out_wdata  output  DATA_W  registered write data.

## Operation
- Handshakes: input is accepted when in_valid && in_ready. Output is consumed when out_valid && out_ready.
- States (skid build): EMPTY (out_valid=0), FULL (main valid, skid empty), SKID (main and skid valid).
- EMPTY: on accept, load main from the input and go to FULL.
- FULL:
  - Accept with consume: main ← input, stay FULL.
  - Accept without consume: skid ← input, go to SKID.
  - Consume without accept: go to EMPTY.
  - Neither: hold.
- SKID: in_ready=0. On consume, main ← skid and go to FULL. Otherwise hold both entries.
- in_ready is registered: 1 in EMPTY and FULL, 0 in SKID. It does not depend on out_ready.
- Entering EMPTY by any path forces out_wd=0, out_wreg=0 and out_wdata=0 (NOP entry).
- flush=1:
  - Next state is EMPTY and both entries are discarded.
  - An input handshake in the same cycle is dropped.
  - flush takes priority over every other transition.
- Payload passes through unmodified; no width conversion.

## Timing
- Reset (rst=0, asynchronous): out_valid=0, out_wd=0, out_wreg=0, out_wdata=0, in_ready=1, skid invalid. Reset takes effect mid-operation without waiting for a clock edge.
- Latency: an entry accepted at edge N appears on out_* after edge N and is valid from that cycle on.
- Throughput: one entry per cycle while out_ready=1.
- Stall: a single out_ready=0 cycle with a concurrent accept is absorbed by the skid. in_ready falls one cycle later.
- Order: entries leave strictly in acceptance order.
- out_* are stable while out_valid=1 && out_ready=0.

## Configuration
- Macro: WB_PIPE_SKID_EN.
- Defined:
  - Skid buffer and SKID state are built.
  - in_ready is a flop output, so no combinational path runs from out_ready to in_ready.
- Undefined:
  - Single register with states EMPTY and FULL only.
  - in_ready = out_ready || !out_valid, a combinational path.
  - Same latency, ordering, flush and reset behaviour; full throughput is retained.

## Test plan
- Reset: drive rst=0 mid-stream with out_valid=1 → outputs clear immediately to 0 and in_ready=1, with no clock edge needed.
- Streaming: out_ready=1; send wd=1..8, wreg=1, wdata=0x100+k on back-to-back cycles → out_valid from cycle 1, the same eight entries in order, one per cycle.
- Skid: send wd=3 (wdata=0xAA) then wd=4 (0xBB); drop out_ready for 2 cycles after the first appears → with WB_PIPE_SKID_EN, in_ready=0 for exactly the stall, then 0xAA and 0xBB are delivered, none lost or duplicated.
- Flush: with SKID state (two entries held), assert flush with in_valid=1 (wd=9) → next cycle out_valid=0 and out_wreg=0; wd=9 is never delivered.
- Drain: FULL with out_ready=1 and in_valid=0 → next cycle out_valid=0, out_wd=0, out_wreg=0, out_wdata=0.
- Random: random in_valid/out_ready/flush over 10k cycles, checked against a scoreboard → order preserved, out_wreg=0 whenever out_valid=0, out_* stable during stalls; run with and without WB_PIPE_SKID_EN.
